// File: rtl/soc_system_fsm_reset_seq.sv
// Avalon-MM reset sequencer for a downstream FSM: timed reset pulse, software hold, ready wait with timeout.
// Optional completion interrupt enabled by defining FSM_RESET_SEQ_IRQ_EN.
module soc_system_fsm_reset_seq #(
  parameter int CNT_W           = 16,
  parameter int DEFAULT_PULSE   = 16,
  parameter int DEFAULT_TIMEOUT = 1024,
  parameter int HOLD_INIT       = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        fsm_ready,
  output logic        fsm_reset_out,
  output logic        busy,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ASSERT     = 2'd1,
    WAIT_READY = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] PULSE_RST   = CNT_W'(DEFAULT_PULSE);
  localparam logic [CNT_W-1:0] TIMEOUT_RST = CNT_W'(DEFAULT_TIMEOUT);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
  localparam logic             HOLD_RST    = (HOLD_INIT != 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] pulseLen_q, pulseLen_d;
  logic [CNT_W-1:0] readyTo_q, readyTo_d;
  logic             hold_q, hold_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic             rstOut_q, rstOut_d;
  logic             irqEn_q, irqEn_d;
  logic             irq_q, irq_d;
  logic             doneSet, timeoutSet;

  logic wr, ctrlWr, pulseWr, statWr, toWr, start, abort;
  logic unusedWd;

  assign wr       = chipselect & ~write_n;
  assign ctrlWr   = wr & (address == 2'd0);
  assign pulseWr  = wr & (address == 2'd1);
  assign statWr   = wr & (address == 2'd2);
  assign toWr     = wr & (address == 2'd3);
  assign start    = ctrlWr & writedata[0];
  assign abort    = ctrlWr & writedata[2];
  assign unusedWd = ^writedata;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hold_d     = ctrlWr ? writedata[1] : hold_q;
    doneSet    = 1'b0;
    timeoutSet = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          // START only counts when the same write also releases HOLD
          if (start && !writedata[1]) begin
            state_d = ASSERT;
            cnt_d   = (pulseLen_q == '0) ? ONE : pulseLen_q;
          end
        end
        ASSERT: begin
          if (cnt_q == ONE) begin
            state_d = WAIT_READY;
            cnt_d   = readyTo_q;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        WAIT_READY: begin
          if (fsm_ready) begin
            state_d = IDLE;
            cnt_d   = '0;
            doneSet = 1'b1;
          end else if (readyTo_q != '0) begin
            if (cnt_q == ONE) begin
              state_d    = IDLE;
              cnt_d      = '0;
              timeoutSet = 1'b1;
            end else begin
              cnt_d = cnt_q - ONE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Hardware set beats a same-cycle software clear
    done_d     = doneSet | (done_q & ~(statWr & writedata[1]));
    timeout_d  = timeoutSet | (timeout_q & ~(statWr & writedata[2]));
    pulseLen_d = (pulseWr && state_q == IDLE) ? writedata[CNT_W-1:0] : pulseLen_q;
    readyTo_d  = (toWr && state_q == IDLE) ? writedata[CNT_W-1:0] : readyTo_q;
    rstOut_d   = (state_d == ASSERT) | hold_d;

`ifdef FSM_RESET_SEQ_IRQ_EN
    irqEn_d = ctrlWr ? writedata[3] : irqEn_q;
    irq_d   = irqEn_d & (done_d | timeout_d);
`else
    irqEn_d = 1'b0;
    irq_d   = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pulseLen_q <= PULSE_RST;
      readyTo_q  <= TIMEOUT_RST;
      hold_q     <= HOLD_RST;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      rstOut_q   <= HOLD_RST;
      irqEn_q    <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pulseLen_q <= pulseLen_d;
      readyTo_q  <= readyTo_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      rstOut_q   <= rstOut_d;
      irqEn_q    <= irqEn_d;
      irq_q      <= irq_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign fsm_reset_out = rstOut_q;
  assign irq           = irq_q;

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: begin
        readdata[1] = hold_q;
        readdata[3] = irqEn_q;
      end
      2'd1: readdata[CNT_W-1:0] = pulseLen_q;
      2'd2: begin
        readdata[0]   = busy;
        readdata[1]   = done_q;
        readdata[2]   = timeout_q;
        readdata[5:4] = state_q;
      end
      2'd3: readdata[CNT_W-1:0] = readyTo_q;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_soc_system_fsm_reset_seq.sv
// Self-checking bench for soc_system_fsm_reset_seq: directed scenarios plus randomized bus/ready traffic
// compared every cycle against a behavioural model. Interrupt checks compile in with FSM_RESET_SEQ_IRQ_EN.
module tb_soc_system_fsm_reset_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        fsm_ready;
  logic        fsm_reset_out;
  logic        busy;
  logic        irq;

  int assertCount = 0;
  int failCount   = 0;
  int hiCount     = 0;

  // Behavioural model: phase 0 idle, 1 pulsing, 2 awaiting ready
  int   mPhase, mPulseLeft, mWaitLeft, mPulseLen, mReadyTo;
  logic mHold, mDone, mTo, mIrqEn, mIrq, mOut;

  logic [31:0] ctrlOpts [12] = '{32'h0, 32'h1, 32'h1, 32'h1, 32'h2, 32'h3,
                                 32'h4, 32'h5, 32'h8, 32'h9, 32'hA, 32'hF};

  always #5 clk = ~clk;

  soc_system_fsm_reset_seq dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .fsm_ready    (fsm_ready),
    .fsm_reset_out(fsm_reset_out),
    .busy         (busy),
    .irq          (irq)
  );

  task automatic modelReset();
    mPhase = 0; mPulseLeft = 0; mWaitLeft = 0;
    mPulseLen = 16; mReadyTo = 1024;
    mHold = 1'b1; mDone = 1'b0; mTo = 1'b0;
    mIrqEn = 1'b0; mIrq = 1'b0; mOut = 1'b1;
  endtask

  task automatic modelStep(input logic w, input logic [1:0] a, input logic [31:0] d, input logic rdy);
    logic ctrlW, statW, wasBusy, dSet, tSet;
    ctrlW   = w && (a == 2'd0);
    statW   = w && (a == 2'd2);
    wasBusy = (mPhase != 0);
    dSet    = 1'b0;
    tSet    = 1'b0;
    if (ctrlW) mHold = d[1];
    if (ctrlW && d[2]) begin
      mPhase = 0;
    end else if (mPhase == 0) begin
      if (ctrlW && d[0] && !d[1]) begin
        mPhase     = 1;
        mPulseLeft = (mPulseLen == 0) ? 1 : mPulseLen;
      end
    end else if (mPhase == 1) begin
      mPulseLeft--;
      if (mPulseLeft == 0) begin
        mPhase    = 2;
        mWaitLeft = mReadyTo;
      end
    end else begin
      if (rdy) begin
        mPhase = 0;
        dSet   = 1'b1;
      end else if (mReadyTo != 0) begin
        mWaitLeft--;
        if (mWaitLeft == 0) begin
          mPhase = 0;
          tSet   = 1'b1;
        end
      end
    end
    mDone = dSet | (mDone & !(statW && d[1]));
    mTo   = tSet | (mTo & !(statW && d[2]));
    if (w && a == 2'd1 && !wasBusy) mPulseLen = int'(d[15:0]);
    if (w && a == 2'd3 && !wasBusy) mReadyTo  = int'(d[15:0]);
`ifdef FSM_RESET_SEQ_IRQ_EN
    if (ctrlW) mIrqEn = d[3];
    mIrq = mIrqEn & (mDone | mTo);
`endif
    mOut = (mPhase == 1) | mHold;
  endtask

  function automatic logic [31:0] modelRead(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      2'd0: begin r[1] = mHold; r[3] = mIrqEn; end
      2'd1: r = 32'(mPulseLen);
      2'd2: begin
        r[0] = (mPhase != 0);
        r[1] = mDone;
        r[2] = mTo;
        r[5:4] = 2'(mPhase);
      end
      default: r = 32'(mReadyTo);
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic sampleAll(input string tag);
    logic [1:0] rdAddr;
    rdAddr     = 2'($urandom_range(0, 3));
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = rdAddr;
    #1;
    if (fsm_reset_out) hiCount++;
    checkOutput({tag, "/rst_out"}, 32'(fsm_reset_out), 32'(mOut));
    checkOutput({tag, "/busy"}, 32'(busy), 32'(mPhase != 0));
    checkOutput({tag, "/irq"}, 32'(irq), 32'(mIrq));
    checkOutput({tag, "/readdata"}, readdata, modelRead(rdAddr));
  endtask

  task automatic applyStimulus(input logic w, input logic [1:0] a, input logic [31:0] d,
                               input logic rdy, input string tag);
    chipselect = w;
    write_n    = ~w;
    address    = a;
    writedata  = d;
    fsm_ready  = rdy;
    modelStep(w, a, d, rdy);
    @(posedge clk);
    #1;
    sampleAll(tag);
  endtask

  task automatic wrReg(input logic [1:0] a, input logic [31:0] d, input string tag);
    applyStimulus(1'b1, a, d, 1'b0, tag);
  endtask

  task automatic idle(input int n, input logic rdy, input string tag);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 32'h0, rdy, tag);
  endtask

  task automatic readCheck(input logic [1:0] a, input logic [31:0] exp, input string tag);
    address = a;
    #1;
    checkOutput(tag, readdata, exp);
  endtask

  task automatic doReset(input string tag);
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    fsm_ready  = 1'b0;
    #1;
    modelReset();
    sampleAll(tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'h0;
    fsm_ready  = 1'b0;
    modelReset();
    @(negedge clk);
    sampleAll("por");
    checkOutput("por_rst_out", 32'(fsm_reset_out), 32'h1);
    readCheck(2'd0, 32'h2, "por_ctrl");
    readCheck(2'd1, 32'd16, "por_pulse_len");
    readCheck(2'd3, 32'd1024, "por_timeout");
    reset = 1'b0;

    wrReg(2'd0, 32'h0, "release");
    checkOutput("release_rst_out", 32'(fsm_reset_out), 32'h0);
    readCheck(2'd0, 32'h0, "release_ctrl");

    wrReg(2'd1, 32'd5, "pl5");
    wrReg(2'd3, 32'd0, "to0");
    hiCount = 0;
    wrReg(2'd0, 32'h1, "start5");
    idle(4, 1'b0, "pulse5");
    idle(3, 1'b0, "wait5");
    checkOutput("wait5_busy", 32'(busy), 32'h1);
    applyStimulus(1'b0, 2'd0, 32'h0, 1'b1, "ready5");
    checkOutput("pulse5_len", 32'(hiCount), 32'd5);
    checkOutput("ready5_busy", 32'(busy), 32'h0);
    readCheck(2'd2, 32'h002, "done_status");
    wrReg(2'd2, 32'h2, "clr_done");
    readCheck(2'd2, 32'h000, "cleared_status");

    wrReg(2'd1, 32'd0, "pl0");
    wrReg(2'd3, 32'd4, "to4");
    hiCount = 0;
    wrReg(2'd0, 32'h1, "start0");
    idle(4, 1'b0, "wait_to");
    readCheck(2'd2, 32'h021, "waiting_status");
    idle(1, 1'b0, "timeout");
    checkOutput("pulse0_len", 32'(hiCount), 32'd1);
    readCheck(2'd2, 32'h004, "timeout_status");
    wrReg(2'd2, 32'h4, "clr_to");

    wrReg(2'd1, 32'hABCD0003, "pl3");
    readCheck(2'd1, 32'd3, "pl3_masked");
    wrReg(2'd3, 32'd0, "to0b");
    hiCount = 0;
    wrReg(2'd0, 32'h1, "start3");
    wrReg(2'd0, 32'h1, "restart_ignored");
    wrReg(2'd1, 32'd7, "pl_busy_write");
    readCheck(2'd1, 32'd3, "pl_unchanged");
    idle(4, 1'b1, "ready3");
    checkOutput("pulse3_len", 32'(hiCount), 32'd3);
    readCheck(2'd2, 32'h002, "done3_status");
    wrReg(2'd2, 32'h2, "clr_done3");

    hiCount = 0;
    wrReg(2'd0, 32'h5, "start_abort");
    idle(2, 1'b0, "no_pulse");
    checkOutput("start_abort_pulses", 32'(hiCount), 32'd0);
    wrReg(2'd1, 32'd10, "pl10");
    wrReg(2'd0, 32'h1, "start10");
    idle(1, 1'b0, "pulse10");
    wrReg(2'd0, 32'h4, "abort");
    checkOutput("abort_rst_out", 32'(fsm_reset_out), 32'h0);
    readCheck(2'd2, 32'h000, "abort_status");

    wrReg(2'd1, 32'd2, "pl2");
    wrReg(2'd0, 32'h1, "start2");
    idle(4, 1'b0, "wait2");
    readCheck(2'd2, 32'h021, "wait2_status");
    doReset("mid_reset");
    checkOutput("mid_reset_rst_out", 32'(fsm_reset_out), 32'h1);
    readCheck(2'd0, 32'h2, "mid_reset_ctrl");
    readCheck(2'd1, 32'd16, "mid_reset_pl");
    readCheck(2'd2, 32'h000, "mid_reset_status");
    readCheck(2'd3, 32'd1024, "mid_reset_to");
    wrReg(2'd0, 32'h0, "release2");

`ifdef FSM_RESET_SEQ_IRQ_EN
    wrReg(2'd1, 32'd1, "irq_pl1");
    wrReg(2'd0, 32'h8, "irq_en");
    wrReg(2'd0, 32'h9, "irq_start");
    idle(3, 1'b1, "irq_ready");
    checkOutput("irq_on_done", 32'(irq), 32'h1);
    wrReg(2'd2, 32'h2, "irq_clr");
    checkOutput("irq_after_w1c", 32'(irq), 32'h0);
    wrReg(2'd0, 32'h0, "irq_dis");
`endif

    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [1:0] a;
      logic [31:0] d;
      r = $urandom_range(0, 99);
      a = 2'($urandom_range(0, 3));
      if (r < 2) begin
        doReset("rnd_reset");
      end else if (r < 25) begin
        case (a)
          2'd0:    d = ctrlOpts[$urandom_range(0, 11)];
          2'd2:    d = 32'($urandom_range(0, 7));
          default: d = 32'($urandom_range(0, 6));
        endcase
        applyStimulus(1'b1, a, d, ($urandom_range(0, 9) < 3), "rnd_write");
      end else begin
        applyStimulus(1'b0, a, 32'h0, ($urandom_range(0, 9) < 3), "rnd_idle");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/soc_system_fsm_reset_seq.md
Name: soc_system_fsm_reset_seq

Overview:
Avalon-MM slave that sequences the reset of the downstream FSM. It replaces the bare one-bit reset PIO with a timed pulse generator, a software hold, and a ready-handshake monitor with timeout. Software starts a reset pulse of programmable length, then the block waits for the FSM to report ready. Completion or timeout is recorded in sticky status bits.

Parameters:
CNT_W, 16, width of the pulse-length and timeout counters (2..31)
DEFAULT_PULSE, 16, reset value of PULSE_LEN
DEFAULT_TIMEOUT, 1024, reset value of READY_TIMEOUT (0 = wait forever)
HOLD_INIT, 1, reset value of CTRL.HOLD (1 = FSM held in reset after system reset until software releases it)

Ports:
clk  in  1  single clock; all logic on the rising edge
reset  in  1  asynchronous, active-high reset
address  in  2  Avalon register word address
chipselect  in  1  Avalon select
write_n  in  1  Avalon write strobe, active-low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data; combinational from address, zero wait states
fsm_ready  in  1  downstream FSM ready flag, synchronous to clk
fsm_reset_out  out  1  registered active-high reset to the downstream FSM
busy  out  1  high while state != IDLE
irq  out  1  completion interrupt (see Optional Feature)

Behaviour:
- Write strobe: wr = chipselect & ~write_n. Register map:
  - addr 0 CTRL. W: bit0 START (pulse, write-1), bit1 HOLD (level), bit2 ABORT (pulse, write-1). R: bit1 = HOLD, all other bits 0.
  - addr 1 PULSE_LEN [CNT_W-1:0]. Writes are ignored while busy.
  - addr 2 STATUS. R: bit0 busy, bit1 DONE, bit2 TIMEOUT, bits[5:4] state. W: bits1/2 are write-1-to-clear.
  - addr 3 READY_TIMEOUT [CNT_W-1:0]. Writes are ignored while busy.
  - Unused bits read 0.
- On reset assertion: state = IDLE, cnt = 0, HOLD = HOLD_INIT, fsm_reset_out = HOLD_INIT, DONE = 0, TIMEOUT = 0, PULSE_LEN and READY_TIMEOUT at their defaults, irq = 0. Reset mid-sequence aborts immediately; no flags are set.
- States are encoded IDLE = 0, ASSERT = 1, WAIT_READY = 2.
- IDLE: START is accepted only when HOLD = 0 and ABORT = 0 in the same write.
  - Accepted at edge N: state = ASSERT, cnt = max(PULSE_LEN, 1).
  - START while HOLD = 1, or while not IDLE, is ignored.
- ASSERT: cnt decrements each cycle.
  - When cnt == 1: next state = WAIT_READY, cnt = READY_TIMEOUT.
  - fsm_reset_out is high for exactly max(PULSE_LEN, 1) cycles, starting at edge N.
- WAIT_READY: fsm_ready sampled high -> IDLE and DONE = 1.
  - Otherwise, if READY_TIMEOUT != 0: cnt decrements; the cycle on which cnt == 1 with fsm_ready low -> IDLE and TIMEOUT = 1.
  - READY_TIMEOUT == 0: wait indefinitely.
  - If fsm_ready is already high on the first WAIT_READY cycle, the sequence completes the next edge.
- fsm_reset_out is the registered value of (next_state == ASSERT) | next_HOLD.
  - Setting HOLD asserts the output from the next edge in any state; the sequencer keeps running.
- ABORT: any state -> IDLE next edge, cnt = 0, no DONE/TIMEOUT set. ABORT together with START: ABORT wins.
- A sticky flag set and a W1C clear of that flag on the same edge: the set wins.
- busy = (state != IDLE), registered with state.

Optional Feature:
Macro FSM_RESET_SEQ_IRQ_EN.
- Defined:
  - Adds CTRL bit3 IRQ_EN (R/W, reset 0).
  - irq = IRQ_EN & (DONE | TIMEOUT), registered. It is deasserted by W1C of both flags or by clearing IRQ_EN.
- Undefined:
  - irq is tied to 0 and CTRL bit3 reads 0 and ignores writes.

Test Plan:
- Release out of reset with HOLD_INIT = 1 -> fsm_reset_out = 1. Write CTRL = 0x0 -> fsm_reset_out = 0 at the next edge; CTRL reads 0x0.
- PULSE_LEN = 5, READY_TIMEOUT = 0, write CTRL = 0x1, fsm_ready rises 3 cycles after the pulse -> fsm_reset_out high exactly 5 cycles, busy falls one edge after fsm_ready, STATUS = 0x002. Write STATUS = 0x2 -> STATUS = 0x000.
- PULSE_LEN = 0, READY_TIMEOUT = 4, fsm_ready held 0 -> 1-cycle pulse, then TIMEOUT after 4 WAIT_READY cycles; STATUS = 0x004.
- START during ASSERT, and a PULSE_LEN write during busy -> both ignored; the pulse length is unchanged and the readback shows the old value.
- Write CTRL = 0x5 (START + ABORT) in IDLE -> no pulse. ABORT at cycle 2 of a 10-cycle pulse -> fsm_reset_out low next edge, STATUS flags 0.
- Assert reset during WAIT_READY -> all registers at defaults, fsm_reset_out = HOLD_INIT. With FSM_RESET_SEQ_IRQ_EN and IRQ_EN = 1, DONE -> irq = 1 until W1C.
